// File: rtl/counter_pkg.sv
// counter_pkg: shared state encoding and default width for the counter family
package counter_pkg;
  localparam int N_DEFAULT = 7;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSE   = 2'd2,
    EXPIRED = 2'd3
  } state_t;
endpackage

// File: rtl/countdown_timer.sv
// countdown_timer: loadable, pausable down-counter with borrow/busy/done flags
// Define COUNTDOWN_TIMER_AUTO_RELOAD_EN to reload load_val on expiry instead of stopping
module countdown_timer
  import counter_pkg::*;
#(
  parameter int n = N_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         tick_in,
  input  logic         start,
  input  logic         stop,
  input  logic [n:0]   load_val,
  output logic [n:0]   count,
  output logic         borrow,
  output logic         busy,
  output logic         done
);
  state_t     state, state_nxt;
  logic [n:0] count_nxt;
  logic       load, expire, reload, dec, borrow_nxt;
  always_comb begin
    load   = start && !stop && (state == IDLE || state == EXPIRED);
    dec    = state == RUN && !stop && tick_in;
    // count of 0 never reaches RUN, so treating <=1 as the last step also rules out wrapping
    expire = dec && count[n:1] == '0;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
    reload = expire && load_val != '0;
`else
    reload = 1'b0;
`endif
    state_nxt  = (load || reload)             ? (load_val == '0 ? EXPIRED : RUN) :
                 expire                       ? EXPIRED :
                 (state == RUN   && stop)     ? PAUSE :
                 (state == PAUSE && stop)     ? IDLE :
                 (state == PAUSE && start)    ? RUN : state;
    count_nxt  = (load || reload)             ? load_val :
                 (expire || (state == PAUSE && stop)) ? '0 :
                 dec                          ? count - 1'b1 : count;
    borrow_nxt = expire || (load && load_val == '0);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      count  <= '0;
      borrow <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_nxt;
      count  <= count_nxt;
      borrow <= borrow_nxt;
      busy   <= state_nxt == RUN || state_nxt == PAUSE;
      done   <= state_nxt == EXPIRED;
    end
  end
endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: scoreboard bench with a behavioural reference model
module tb_countdown_timer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick_in = 1'b0, start = 1'b0, stop = 1'b0;
  logic [7:0] load_val = '0;
  logic [7:0] count;
  logic       borrow, busy, done;
  typedef struct packed {
    logic [7:0] c;
    logic       b;
    logic       bz;
    logic       d;
  } exp_t;
  exp_t  q[$];
  string nq[$];
  int    vecs = 0, errs = 0;
  string mode = "idle";
  int    mc = 0;
  countdown_timer dut (
    .clk(clk), .rst_n(rst_n), .tick_in(tick_in), .start(start), .stop(stop),
    .load_val(load_val), .count(count), .borrow(borrow), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  task automatic model(input bit st, input bit sp, input bit tk, input int lv, output bit b);
    b = 0;
    if (sp) begin
      if (mode == "run") mode = "pause";
      else if (mode == "pause") begin mode = "idle"; mc = 0; end
    end else if (st && (mode == "idle" || mode == "exp")) begin
      if (lv == 0) begin mode = "exp"; mc = 0; b = 1; end
      else begin mode = "run"; mc = lv; end
    end else if (st && mode == "pause") mode = "run";
    else if (mode == "run" && tk) begin
      mc = mc - 1;
      if (mc == 0) begin
        b = 1;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
        if (lv != 0) mc = lv; else mode = "exp";
`else
        mode = "exp";
`endif
      end
    end
  endtask
  task automatic cyc(input bit st, input bit sp, input bit tk, input logic [7:0] lv, input string nm);
    bit b;
    exp_t e;
    @(negedge clk);
    start = st; stop = sp; tick_in = tk; load_val = lv;
    model(st, sp, tk, int'(lv), b);
    e.c = mc[7:0]; e.b = b; e.bz = (mode == "run" || mode == "pause"); e.d = (mode == "exp");
    q.push_back(e);
    nq.push_back(nm);
  endtask
  task automatic check_now(input string nm, input exp_t e);
    vecs++;
    if ({count, borrow, busy, done} !== e) begin
      errs++;
      $display("FAIL %s: got count=%0d borrow=%0b busy=%0b done=%0b, want count=%0d borrow=%0b busy=%0b done=%0b",
               nm, count, borrow, busy, done, e.c, e.b, e.bz, e.d);
    end
  endtask
  initial begin
    exp_t e;
    string nm;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        nm = nq.pop_front();
        check_now(nm, e);
      end
    end
  end
  initial begin
    @(negedge clk);
    #2 check_now("reset_state", '0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1, 0, 0, 8'd3, "load3");
    repeat (3) cyc(0, 0, 1, 8'd3, "tick3");
    cyc(0, 0, 0, 8'd3, "expired_hold");
    cyc(1, 1, 0, 8'd3, "start_stop_expired");
    cyc(1, 0, 0, 8'd5, "load5");
    repeat (2) cyc(0, 0, 1, 8'd5, "tick5");
    cyc(0, 1, 1, 8'd5, "stop_with_tick");
    repeat (3) cyc(0, 0, 1, 8'd5, "pause_tick");
    cyc(1, 0, 0, 8'd5, "resume");
    repeat (3) cyc(0, 0, 1, 8'd5, "resume_tick");
    cyc(1, 0, 0, 8'd9, "to_idle_load");
    repeat (2) cyc(0, 1, 0, 8'd9, "to_idle_stop");
    cyc(1, 0, 0, 8'd0, "load_zero");
    cyc(0, 0, 0, 8'd0, "load_zero_hold");
    cyc(1, 0, 0, 8'd9, "to_idle_load");
    repeat (2) cyc(0, 1, 0, 8'd9, "to_idle_stop");
    cyc(1, 1, 0, 8'd9, "start_stop_idle");
    cyc(1, 0, 0, 8'd9, "load9");
    cyc(1, 0, 1, 8'd9, "start_held_run");
    cyc(0, 1, 0, 8'd9, "pause");
    cyc(0, 1, 0, 8'd9, "abort");
    cyc(1, 0, 0, 8'd2, "load2");
    repeat (6) cyc(0, 0, 1, 8'd2, "cont_tick");
    cyc(1, 1, 0, 8'd200, "to_idle_ss");
    cyc(0, 1, 0, 8'd200, "to_idle_stop");
    cyc(0, 1, 0, 8'd200, "to_idle_stop");
    cyc(1, 0, 0, 8'd200, "load200");
    cyc(0, 0, 0, 8'd200, "hold200");
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_now("async_reset", '0);
    mode = "idle"; mc = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) cyc(0, 0, 1, 8'd200, "post_reset");
    repeat (400) begin
      logic [7:0] lv;
      lv = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 4));
      cyc($urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1, lv, "random");
    end
    repeat (3) @(posedge clk);
    #2;
    vecs++;
    if (q.size() != 0) begin
      errs++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 The block SHALL have parameter n, default 7, meaning counter MSB index; the counter width is n+1 bits.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, an asynchronous active-low reset.
REQ-004 The block SHALL have port tick_in, input, 1, a decrement enable, typically the carry of an upstream up-counter.
REQ-005 The block SHALL have port start, input, 1, which loads or resumes the count.
REQ-006 The block SHALL have port stop, input, 1, which pauses, or aborts from pause.
REQ-007 The block SHALL have port load_val, input, n+1, the reload value, sampled on load.
REQ-008 The block SHALL have port count, output reg, n+1, the current count.
REQ-009 The block SHALL have port borrow, output reg, 1, a one-cycle pulse when count reaches 0.
REQ-010 The block SHALL have port busy, output reg, 1, high in the RUN or PAUSE state.
REQ-011 The block SHALL have port done, output reg, 1, a level that is high in the EXPIRED state.

Function
REQ-012 The FSM SHALL have the states IDLE, RUN, PAUSE and EXPIRED; count, borrow, busy and done SHALL be registered, so they reflect the state entered at the edge.
REQ-013 IDLE with start=1 and stop=0 SHALL load count<=load_val and go to RUN; with load_val==0 it SHALL go to EXPIRED and pulse borrow instead.
REQ-014 RUN with tick_in=1 and count>1 SHALL decrement count by 1.
REQ-015 RUN with tick_in=1 and count==1 SHALL set count<=0, pulse borrow high for one cycle, and go to EXPIRED.
REQ-016 RUN with tick_in=0 SHALL hold count.
REQ-017 RUN with stop=1 SHALL go to PAUSE and hold count, with no decrement even if tick_in=1 that cycle.
REQ-018 PAUSE SHALL ignore tick_in.
REQ-019 PAUSE with start=1 SHALL resume RUN without reloading.
REQ-020 PAUSE with stop=1 SHALL clear count to 0 and go to IDLE.
REQ-021 EXPIRED SHALL hold count=0 and done=1; start=1 there SHALL reload count<=load_val and go to RUN, following the same rule as REQ-013 when load_val==0.
REQ-022 When start and stop are asserted in the same cycle, stop SHALL win in every state; in IDLE and EXPIRED that cycle is a no-op.
REQ-023 count SHALL never wrap below 0; a decrement from 0 is impossible by construction.
REQ-024 start held high continuously in RUN SHALL have no effect; it SHALL not cause a reload.
REQ-025 borrow SHALL never be high for two consecutive cycles unless expiry occurs on consecutive ticks in auto-reload mode with load_val==1.

Reset
REQ-026 rst_n=0 SHALL asynchronously force state to IDLE and count, borrow, busy and done to 0.
REQ-027 Reset asserted mid-RUN SHALL discard the count in progress; no borrow SHALL be emitted on reset release.

Configuration
REQ-028 The macro COUNTDOWN_TIMER_AUTO_RELOAD_EN SHALL select the expiry behaviour as follows.
REQ-029 With COUNTDOWN_TIMER_AUTO_RELOAD_EN defined, the REQ-015 expiry SHALL pulse borrow, load count<=load_val in the same edge, and stay in RUN.
- done SHALL remain 0 on these expiries.
- If load_val==0 at that edge, the block SHALL go to EXPIRED instead.
REQ-030 Without COUNTDOWN_TIMER_AUTO_RELOAD_EN, expiry SHALL always go to EXPIRED, as in REQ-015.

Structure
REQ-031 The state encoding (2-bit localparams IDLE=0, RUN=1, PAUSE=2, EXPIRED=3) SHALL be defined in the shared package counter_pkg.
REQ-032 counter_pkg SHALL also hold the default width constant (7).
REQ-033 No sub-module is required; the block SHALL be a single FSM plus a counter register, directly cascadable after the existing up-counter with its carry driving tick_in.

Verification (n=7)
REQ-034 The bench SHALL load load_val=3, pulse start, then give three tick_in pulses.
- count SHALL read 3,2,1,0.
- borrow SHALL be high exactly one cycle, with count=0.
- done SHALL then be 1 and busy 0.
REQ-035 The bench SHALL load load_val=5, give 2 ticks, assert stop with tick_in=1, give 3 more ticks, then start, then 3 ticks.
- count SHALL hold at 3 through the pause.
- count SHALL reach 0 after the resume ticks.
- No reload SHALL occur on resume.
REQ-036 The bench SHALL assert start with load_val=0 from IDLE; the next cycle SHALL show done=1, borrow pulsed once, and busy never 1.
REQ-037 The bench SHALL assert start and stop in the same cycle in IDLE, then stop again in PAUSE.
- The start+stop cycle in IDLE SHALL leave the state at IDLE.
- stop in PAUSE SHALL give count=0 and IDLE.
REQ-038 The bench SHALL drive rst_n low asynchronously (mid-clock) while in RUN at count=200; all outputs SHALL be 0 immediately, and no borrow SHALL appear after release.
REQ-039 With COUNTDOWN_TIMER_AUTO_RELOAD_EN defined, load_val=2 and continuous tick_in, the bench SHALL check the following.
- borrow SHALL fire every 2nd cycle.
- count SHALL follow 2,1,2,1 (the reload replaces 0).
- done SHALL stay 0.
